// File: rtl/ddr2_pipe_xfer_pkg.sv
// Shared constants and FSM state type for the host-pipe <-> MIG DDR2 transfer engine.
package ddr2_pipe_xfer_pkg;

   localparam logic [2:0] CMD_WR      = 3'b000;
   localparam logic [2:0] CMD_RD      = 3'b001;
   localparam int         BURST_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE,
      WR0,
      WR1,
      RDC
   } xfer_state_t;

endpackage

// File: rtl/ddr2_pipe_xfer_fifo.sv
// Single-clock word FIFO; each push stores IN_WORDS words, each pop removes OUT_WORDS words.
module sync_word_fifo #(
   parameter int DEPTH     = 1024,
   parameter int WORD_W    = 16,
   parameter int IN_WORDS  = 1,
   parameter int OUT_WORDS = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic [IN_WORDS*WORD_W-1:0]    push_data,
   input  logic                          pop,
   output logic [OUT_WORDS*WORD_W-1:0]   pop_data,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int AW = $clog2(DEPTH);

   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push_ok;
   logic              pop_ok;

   // Full/empty decisions use the count before this cycle's pop, so a push
   // into a full buffer is dropped even if a pop happens in the same cycle.
   assign push_ok = push && (count <= (AW+1)'(DEPTH - IN_WORDS));
   assign pop_ok  = pop && (count >= (AW+1)'(OUT_WORDS));

   always_comb begin
      pop_data = '0;
      for (int i = 0; i < OUT_WORDS; i++)
         pop_data[i*WORD_W +: WORD_W] = mem[rd_ptr + AW'(i)];
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         for (int i = 0; i < IN_WORDS; i++)
            mem[wr_ptr + AW'(i)] <= push_data[i*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(IN_WORDS);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(OUT_WORDS);
         count <= count + (push_ok ? (AW+1)'(IN_WORDS) : '0)
                        - (pop_ok ? (AW+1)'(OUT_WORDS) : '0);
      end
   end

endmodule

// File: rtl/ddr2_pipe_xfer.sv
// Buffers 16-bit host words and moves them to/from the MIG DDR2 user interface in
// 4-word bursts at sequential addresses (write mode) or as sequential prefetch (read mode).
module ddr2_pipe_xfer
   import ddr2_pipe_xfer_pkg::*;
#(
   parameter int FIFO_DEPTH = 1024,
   parameter int ADDR_BITS  = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mode,
   input  logic        phy_init_done,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        rd_en,
   output logic [15:0] rd_data,
   input  logic        rd_data_valid,
   input  logic [31:0] rd_data_fifo_out,
   input  logic        app_af_afull,
   input  logic        app_wdf_afull,
   output logic        app_af_wren,
   output logic [30:0] app_af_addr,
   output logic [2:0]  app_af_cmd,
   output logic        app_wdf_wren,
   output logic [31:0] app_wdf_data,
   output logic [3:0]  app_wdf_mask_data
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   xfer_state_t          state;
   xfer_state_t          state_nxt;
   logic                 issue_wr;
   logic                 issue_rd;
   logic                 wb_pop;
   logic                 rb_pop;
   logic                 rd_room;
   logic [CW-1:0]        wb_count;
   logic [CW-1:0]        rb_count;
   logic [CW-1:0]        outstanding;
   logic [31:0]          wb_head;
   logic [15:0]          rb_head;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [ADDR_BITS-1:0] rd_addr;

   sync_word_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .WORD_W    (16),
      .IN_WORDS  (1),
      .OUT_WORDS (2)
   ) u_wr_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (wb_pop),
      .pop_data  (wb_head),
      .count     (wb_count)
   );

   sync_word_fifo #(
      .DEPTH     (FIFO_DEPTH),
      .WORD_W    (16),
      .IN_WORDS  (2),
      .OUT_WORDS (1)
   ) u_rd_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (rd_data_valid),
      .push_data (rd_data_fifo_out),
      .pop       (rb_pop),
      .pop_data  (rb_head),
      .count     (rb_count)
   );

   // Outputs are registered on the edge that enters a state, so the beat for
   // words 0-1 is popped when leaving IDLE and words 2-3 when leaving WR0.
   assign wb_pop            = issue_wr || (state == WR0);
   assign rb_pop            = rd_en && (rb_count != '0);
   assign rd_room           = ({1'b0, rb_count} + {1'b0, outstanding} + (CW+1)'(BURST_WORDS))
                              <= (CW+1)'(FIFO_DEPTH);
   assign app_wdf_mask_data = 4'b0000;

   always_comb begin
      state_nxt = state;
      issue_wr  = 1'b0;
      issue_rd  = 1'b0;
      case (state)
         IDLE: begin
            if (phy_init_done && !app_af_afull) begin
               if (!mode && (wb_count >= CW'(BURST_WORDS)) && !app_wdf_afull) begin
                  issue_wr  = 1'b1;
                  state_nxt = WR0;
               end else if (mode && rd_room) begin
                  issue_rd  = 1'b1;
                  state_nxt = RDC;
               end
            end
         end
         WR0:     state_nxt = WR1;
         WR1:     state_nxt = IDLE;
         RDC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         wr_addr      <= '0;
         rd_addr      <= '0;
         outstanding  <= '0;
         app_af_wren  <= 1'b0;
         app_af_addr  <= '0;
         app_af_cmd   <= CMD_WR;
         app_wdf_wren <= 1'b0;
         app_wdf_data <= '0;
         rd_data      <= '0;
      end else begin
         state        <= state_nxt;
         app_af_wren  <= issue_wr || issue_rd;
         app_wdf_wren <= wb_pop;
         if (issue_wr) begin
            app_af_addr <= {{(31-ADDR_BITS){1'b0}}, wr_addr};
            app_af_cmd  <= CMD_WR;
            wr_addr     <= wr_addr + ADDR_BITS'(BURST_WORDS);
         end
         if (issue_rd) begin
            app_af_addr <= {{(31-ADDR_BITS){1'b0}}, rd_addr};
            app_af_cmd  <= CMD_RD;
            rd_addr     <= rd_addr + ADDR_BITS'(BURST_WORDS);
         end
         if (wb_pop)
            app_wdf_data <= wb_head;
         outstanding <= outstanding + (issue_rd ? CW'(BURST_WORDS) : '0)
                                    - (rd_data_valid ? CW'(2) : '0);
         if (rb_pop)
            rd_data <= rb_head;
      end
   end

endmodule

// File: tb/tb_ddr2_pipe_xfer.sv
// Randomised bench for ddr2_pipe_xfer: a DDR2 memory model answers the DUT, and a
// word-queue reference predicts addresses, write beats and host read data.
module tb_ddr2_pipe_xfer;
   import ddr2_pipe_xfer_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        mode;
   logic        phy_init_done;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        rd_en;
   logic [15:0] rd_data;
   logic        rd_data_valid;
   logic [31:0] rd_data_fifo_out;
   logic        app_af_afull;
   logic        app_wdf_afull;
   logic        app_af_wren;
   logic [30:0] app_af_addr;
   logic [2:0]  app_af_cmd;
   logic        app_wdf_wren;
   logic [31:0] app_wdf_data;
   logic [3:0]  app_wdf_mask_data;

   int total = 0;
   int bad   = 0;

   logic [15:0] mem_m [int];
   logic [15:0] wq[$];
   logic [15:0] rd_exp_q[$];
   int          rdq[$];
   int          exp_wr_addr = 0;
   int          exp_rd_addr = 0;
   int          cur_wa      = 0;
   int          beat        = 0;
   int          wr_cmds     = 0;
   int          rd_cmds     = 0;
   bit          resp_busy   = 1'b0;
   logic [15:0] last_rd;

   ddr2_pipe_xfer dut (
      .clk               (clk),
      .reset             (reset),
      .mode              (mode),
      .phy_init_done     (phy_init_done),
      .wr_en             (wr_en),
      .wr_data           (wr_data),
      .rd_en             (rd_en),
      .rd_data           (rd_data),
      .rd_data_valid     (rd_data_valid),
      .rd_data_fifo_out  (rd_data_fifo_out),
      .app_af_afull      (app_af_afull),
      .app_wdf_afull     (app_wdf_afull),
      .app_af_wren       (app_af_wren),
      .app_af_addr       (app_af_addr),
      .app_af_cmd        (app_af_cmd),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_mask_data (app_wdf_mask_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] mem_rd(input int a);
      return mem_m.exists(a) ? mem_m[a] : 16'h0000;
   endfunction

   // Controller side: observe commands and write beats between edges.
   initial begin
      forever begin
         @(negedge clk);
         if (app_af_wren) begin
            if (app_af_cmd == CMD_WR) begin
               chk("wr_addr", 32'(app_af_addr), 32'(exp_wr_addr));
               exp_wr_addr += BURST_WORDS;
               cur_wa = int'(app_af_addr);
               beat   = 0;
               wr_cmds++;
            end else begin
               chk("rd_cmd", 32'(app_af_cmd), 32'(CMD_RD));
               chk("rd_addr", 32'(app_af_addr), 32'(exp_rd_addr));
               exp_rd_addr += BURST_WORDS;
               rdq.push_back(int'(app_af_addr));
               rd_cmds++;
            end
         end
         if (app_wdf_wren) begin
            if (wq.size() < 2) begin
               chk("wdf_unexpected", 32'(wq.size()), 32'd2);
            end else begin
               chk("wdf_data", app_wdf_data, {wq[1], wq[0]});
               void'(wq.pop_front());
               void'(wq.pop_front());
            end
            chk("wdf_mask", 32'(app_wdf_mask_data), 32'd0);
            mem_m[cur_wa + 2*beat]     = app_wdf_data[15:0];
            mem_m[cur_wa + 2*beat + 1] = app_wdf_data[31:16];
            beat++;
         end
      end
   end

   // Memory read return: two beats per command after a random delay.
   initial begin
      int a;
      forever begin
         @(posedge clk);
         if (rdq.size() != 0) begin
            resp_busy = 1'b1;
            a = rdq.pop_front();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            rd_data_valid    = 1'b1;
            rd_data_fifo_out = {mem_rd(a + 1), mem_rd(a)};
            @(posedge clk);
            #1;
            rd_data_fifo_out = {mem_rd(a + 3), mem_rd(a + 2)};
            @(posedge clk);
            #1;
            rd_data_valid = 1'b0;
            resp_busy     = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_words(input int n);
      logic [15:0] w;
      for (int i = 0; i < n; i++) begin
         w       = 16'($urandom);
         wr_data = w;
         wr_en   = 1'b1;
         wq.push_back(w);
         rd_exp_q.push_back(w);
         @(posedge clk);
         #1;
      end
      wr_en = 1'b0;
   endtask

   task automatic pop_words(input int n);
      logic [15:0] e;
      rd_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (i == n - 1)
            rd_en = 1'b0;
         e = (rd_exp_q.size() != 0) ? rd_exp_q.pop_front() : 16'h0000;
         chk("rd_data", 32'(rd_data), 32'(e));
         last_rd = e;
      end
   endtask

   task automatic wait_quiet();
      bit done = 1'b0;
      wait_cycles(8);
      for (int i = 0; i < 500; i++) begin
         if (rdq.size() == 0 && !resp_busy && !rd_data_valid) begin
            done = 1'b1;
            break;
         end
         wait_cycles(1);
      end
      chk("quiet_reached", 32'(done), 32'd1);
      wait_cycles(4);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wq.delete();
      rd_exp_q.delete();
      rdq.delete();
      exp_wr_addr = 0;
      exp_rd_addr = 0;
      wr_cmds     = 0;
      rd_cmds     = 0;
      wait_cycles(3);
      reset = 1'b0;
   endtask

   // Lets exactly one read command through, then blocks further commands and drops mode.
   task automatic one_read_then_stop();
      int  n0 = rd_cmds;
      bit  got = 1'b0;
      mode         = 1'b1;
      app_af_afull = 1'b0;
      for (int i = 0; i < 60; i++) begin
         wait_cycles(1);
         if (rd_cmds > n0) begin
            got = 1'b1;
            break;
         end
      end
      app_af_afull = 1'b1;
      mode         = 1'b0;
      chk("rd_cmd_seen", 32'(got), 32'd1);
   endtask

   initial begin
      bit wr_done;
      reset            = 1'b1;
      mode             = 1'b0;
      phy_init_done    = 1'b1;
      wr_en            = 1'b0;
      wr_data          = '0;
      rd_en            = 1'b0;
      rd_data_valid    = 1'b0;
      rd_data_fifo_out = '0;
      app_af_afull     = 1'b0;
      app_wdf_afull    = 1'b0;
      last_rd          = '0;
      wait_cycles(3);
      reset = 1'b0;

      chk("rst_af_wren",  32'(app_af_wren),  32'd0);
      chk("rst_wdf_wren", 32'(app_wdf_wren), 32'd0);
      chk("rst_af_addr",  32'(app_af_addr),  32'd0);
      chk("rst_af_cmd",   32'(app_af_cmd),   32'd0);
      chk("rst_wdf_data", app_wdf_data,      32'd0);
      chk("rst_rd_data",  32'(rd_data),      32'd0);

      // Three words never make a burst; the fourth does.
      push_words(3);
      wait_cycles(10);
      chk("cmds_after_3", 32'(wr_cmds), 32'd0);
      push_words(1);
      wait_cycles(10);
      chk("cmds_after_4", 32'(wr_cmds), 32'd1);
      push_words(12);
      wait_cycles(40);
      chk("cmds_after_16", 32'(wr_cmds), 32'd4);
      chk("wq_drained_16", 32'(wq.size()), 32'd0);

      mode = 1'b1;
      wait_cycles(120);
      pop_words(16);
      mode = 1'b0;
      wait_quiet();
      do_reset();
      chk("rst2_rd_data", 32'(rd_data), 32'd0);
      chk("rst2_af_addr", 32'(app_af_addr), 32'd0);

      // 256-word round trip after reset.
      push_words(256);
      wr_done = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (wq.size() == 0) begin
            wr_done = 1'b1;
            break;
         end
         wait_cycles(1);
      end
      wait_cycles(10);
      chk("wr256_drained", 32'(wr_done), 32'd1);
      chk("cmds_256", 32'(wr_cmds), 32'd64);
      mode = 1'b1;
      wait_cycles(120);
      for (int c = 0; c < 16; c++) begin
         pop_words(16);
         wait_cycles(100);
      end
      mode = 1'b0;
      wait_quiet();
      do_reset();

      // Address FIFO almost full blocks both directions, then commands resume in order.
      app_af_afull = 1'b1;
      push_words(8);
      wait_cycles(20);
      chk("afull_no_wr", 32'(wr_cmds), 32'd0);
      mode = 1'b1;
      wait_cycles(20);
      chk("afull_no_rd", 32'(rd_cmds), 32'd0);
      mode         = 1'b0;
      app_af_afull = 1'b0;
      wait_cycles(30);
      chk("afull_release_wr", 32'(wr_cmds), 32'd2);

      // Mode drops with a read outstanding; its data must still land.
      one_read_then_stop();
      wait_cycles(30);
      pop_words(4);
      rd_en = 1'b1;
      wait_cycles(1);
      rd_en = 1'b0;
      wait_cycles(2);
      chk("rd_empty_hold", 32'(rd_data), 32'(last_rd));
      one_read_then_stop();
      wait_cycles(30);
      pop_words(4);
      chk("rd_cmds_final", 32'(rd_cmds), 32'd2);
      chk("rd_exp_left", 32'(rd_exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
